gpio_filt: RTL and testbench
============================

# gpio_filt

Parametrised GPIO peripheral with per-pin input synchronisation, a programmable glitch filter, per-pin rise/fall/level interrupt detection and atomic set/clear output updates. It sits behind the peripheral register bus next to the existing TL-UL GPIO and serves SoC variants that need fewer or differently-filtered pins. Bus accesses are single-cycle request, next-cycle response.

## Interface
- Width, 32, number of pins (1..32); register bits at or above Width read 0 and ignore writes.
- FiltCycles, 16, filter stability window in cycles (2..256); counter width $clog2(FiltCycles).
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- reg_req_i  in  1  access request, one cycle per access.
- reg_we_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  6  byte address.
- reg_wdata_i  in  32  write data.
- reg_rvalid_o  out  1  response valid, exactly one cycle after reg_req_i.
- reg_rdata_o  out  32  read data, valid with reg_rvalid_o, 0 for writes.
- reg_error_o  out  1  access error, valid with reg_rvalid_o.
- cio_gpio_i  in  Width  raw pad inputs (asynchronous).
- cio_gpio_o  out  Width  output data.
- cio_gpio_en_o  out  Width  output enable.
- intr_gpio_o  out  Width  per-pin interrupt, INTR_STATE & INTR_ENABLE.

## Operation
- Registers (byte offset): 0x00 DATA_IN (RO, filtered input); 0x04 DATA_OUT (RW); 0x08 DATA_OUT_SET (W, 1 sets bit); 0x0C DATA_OUT_CLR (W, 1 clears bit); 0x10 OE (RW); 0x14 FILTER_EN (RW); 0x18 INTR_STATE (R, W1C); 0x1C INTR_ENABLE (RW); 0x20 RISE_EN; 0x24 FALL_EN; 0x28 LVLHI_EN; 0x2C LVLLO_EN; 0x30 INTR_TEST (W, 1 sets INTR_STATE bit).
- Write-only registers read 0. Offsets >= 0x34 or reg_addr_i[1:0] != 0: reg_error_o = 1, no state change, rdata 0.
- Input path per pin: 2-flop synchroniser -> s2. FILTER_EN bit 0: filt_q <= s2 every cycle. Bit 1: cand_q/cnt_q; if s2 != cand_q then cand_q <= s2, cnt_q <= 0; else if cnt_q != FiltCycles-1 then cnt_q++; else filt_q <= cand_q. cand_q, cnt_q update regardless of FILTER_EN, so toggling FILTER_EN causes no spurious filt_q change beyond current s2/cand_q.
- DATA_IN = filt_q.
- Interrupt detect: prev_q <= filt_q each cycle. Per pin, set = (RISE_EN & filt_q & ~prev_q) | (FALL_EN & ~filt_q & prev_q) | (LVLHI_EN & filt_q) | (LVLLO_EN & ~filt_q) | INTR_TEST write bit.
- INTR_STATE bit: set has priority over a same-cycle W1C; level sources re-set every cycle while active.
- cio_gpio_o = DATA_OUT, cio_gpio_en_o = OE, both straight from flops.

## Timing
- Reset: all registers, synchronisers, filt_q, prev_q, cand_q, cnt_q = 0; all outputs 0; reg_rvalid_o = 0.
- Bus: request at edge N -> reg_rvalid_o/rdata/error high for the cycle after edge N; back-to-back requests every cycle supported. Write effect visible on outputs after edge N; a read at edge N+1 returns the new value.
- Input, unfiltered: pad change before edge 1 -> DATA_IN changes after edge 3; INTR_STATE edge bit set after edge 4.
- Input, filtered: DATA_IN changes after edge 2+FiltCycles+1; any s2 glitch restarts the window; pulses shorter than FiltCycles+1 synchronised cycles never reach filt_q.
- Reset assertion mid-filter or mid-access: immediate clear; no response for the aborted request.

## Test plan
- Reset then read all offsets -> all 0, reg_error_o 0; read 0x34 and 0x05 -> reg_error_o 1, rdata 0.
- Write DATA_OUT=0x0000_00F0, SET 0x0F, CLR 0x30 -> cio_gpio_o = 0x0000_00CF; readback of 0x08/0x0C = 0.
- FILTER_EN=0, RISE_EN=1, INTR_ENABLE=1 (pin 0): raise cio_gpio_i[0] -> DATA_IN[0]=1 after 3 edges, intr_gpio_o[0]=1 after 4; W1C 0x18 bit 0 -> 0.
- FiltCycles=16, FILTER_EN=1: 10-cycle pulse on pin 3 -> DATA_IN unchanged, no interrupt; 20-cycle high -> DATA_IN[3]=1 at edge 19.
- LVLHI_EN=1 pin 2 held high, W1C same cycle as set -> INTR_STATE[2] stays 1; INTR_TEST 0x80 -> INTR_STATE[7]=1.
- Width=8: write 0xFFFF_FFFF to OE -> cio_gpio_en_o=0xFF, readback 0x0000_00FF.

Source files
------------

// File: rtl/gpio_filt.sv
// GPIO with 2-flop input sync, per-pin glitch filter, edge/level interrupts
// and atomic set/clear output updates behind a single-cycle register bus.
module gpio_filt #(
  parameter int Width      = 32,
  parameter int FiltCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             reg_req_i,
  input  logic             reg_we_i,
  input  logic [5:0]       reg_addr_i,
  input  logic [31:0]      reg_wdata_i,
  output logic             reg_rvalid_o,
  output logic [31:0]      reg_rdata_o,
  output logic             reg_error_o,
  input  logic [Width-1:0] cio_gpio_i,
  output logic [Width-1:0] cio_gpio_o,
  output logic [Width-1:0] cio_gpio_en_o,
  output logic [Width-1:0] intr_gpio_o
);

  localparam int CntW = $clog2(FiltCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(FiltCycles - 1);

  logic [Width-1:0] r_sync1, r_sync2, r_filt, r_prev, r_cand;
  logic [CntW-1:0]  r_cnt [Width];
  logic [Width-1:0] r_dout, r_oe, r_filt_en, r_intr_state, r_intr_en;
  logic [Width-1:0] r_rise_en, r_fall_en, r_lvlhi_en, r_lvllo_en;
  logic             r_rvalid, r_error;
  logic [31:0]      r_rdata;

  logic             w_addr_ok, w_wr;
  logic [3:0]       w_idx;
  logic [12:0]      w_wsel;
  logic [Width-1:0] w_wdata, w_filt_nxt, w_set, w_intr_nxt, w_rd;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  assign w_unused_wdata = ^reg_wdata_i;
  assign w_addr_ok = (reg_addr_i[1:0] == 2'b00) && (reg_addr_i < 6'h34);
  assign w_wr      = reg_req_i && reg_we_i && w_addr_ok;
  assign w_idx     = reg_addr_i[5:2];
  assign w_wsel    = w_wr ? (13'(1) << w_idx) : '0;
  assign w_wdata   = reg_wdata_i[Width-1:0];

  // A pin's filter output only moves once its candidate has been stable for the full window
  always_comb begin
    w_filt_nxt = r_filt;
    for (int i = 0; i < Width; i++) begin
      if (!r_filt_en[i])
        w_filt_nxt[i] = r_sync2[i];
      else if ((r_sync2[i] == r_cand[i]) && (r_cnt[i] == CntMax))
        w_filt_nxt[i] = r_cand[i];
    end
  end

  assign w_set = (r_rise_en  &  r_filt & ~r_prev) |
                 (r_fall_en  & ~r_filt &  r_prev) |
                 (r_lvlhi_en &  r_filt) |
                 (r_lvllo_en & ~r_filt) |
                 (w_wsel[12] ? w_wdata : '0);
  assign w_intr_nxt = (r_intr_state & ~(w_wsel[6] ? w_wdata : '0)) | w_set;

  always_comb begin
    w_rd = '0;
    case (w_idx)
      4'd0:    w_rd = r_filt;
      4'd1:    w_rd = r_dout;
      4'd4:    w_rd = r_oe;
      4'd5:    w_rd = r_filt_en;
      4'd6:    w_rd = r_intr_state;
      4'd7:    w_rd = r_intr_en;
      4'd8:    w_rd = r_rise_en;
      4'd9:    w_rd = r_fall_en;
      4'd10:   w_rd = r_lvlhi_en;
      4'd11:   w_rd = r_lvllo_en;
      default: w_rd = '0;
    endcase
    w_rdata = '0;
    w_rdata[Width-1:0] = w_rd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      r_prev  <= '0;
      r_cand  <= '0;
      for (int i = 0; i < Width; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= cio_gpio_i;
      r_sync2 <= r_sync1;
      r_filt  <= w_filt_nxt;
      r_prev  <= r_filt;
      for (int i = 0; i < Width; i++) begin
        if (r_sync2[i] != r_cand[i]) begin
          r_cand[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else if (r_cnt[i] != CntMax) begin
          r_cnt[i]  <= r_cnt[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dout       <= '0;
      r_oe         <= '0;
      r_filt_en    <= '0;
      r_intr_state <= '0;
      r_intr_en    <= '0;
      r_rise_en    <= '0;
      r_fall_en    <= '0;
      r_lvlhi_en   <= '0;
      r_lvllo_en   <= '0;
    end else begin
      if (w_wsel[1])      r_dout <= w_wdata;
      else if (w_wsel[2]) r_dout <= r_dout | w_wdata;
      else if (w_wsel[3]) r_dout <= r_dout & ~w_wdata;
      if (w_wsel[4])  r_oe       <= w_wdata;
      if (w_wsel[5])  r_filt_en  <= w_wdata;
      if (w_wsel[7])  r_intr_en  <= w_wdata;
      if (w_wsel[8])  r_rise_en  <= w_wdata;
      if (w_wsel[9])  r_fall_en  <= w_wdata;
      if (w_wsel[10]) r_lvlhi_en <= w_wdata;
      if (w_wsel[11]) r_lvllo_en <= w_wdata;
      r_intr_state <= w_intr_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_error  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= reg_req_i;
      r_error  <= reg_req_i && !w_addr_ok;
      r_rdata  <= (reg_req_i && !reg_we_i && w_addr_ok) ? w_rdata : '0;
    end
  end

  assign reg_rvalid_o  = r_rvalid;
  assign reg_rdata_o   = r_rdata;
  assign reg_error_o   = r_error;
  assign cio_gpio_o    = r_dout;
  assign cio_gpio_en_o = r_oe;
  assign intr_gpio_o   = r_intr_state & r_intr_en;

endmodule

// File: tb/tb_gpio_filt.sv
// Self-checking bench for gpio_filt: register table, timed input/interrupt
// sequences, randomized output-register traffic against a simple model.
module tb_gpio_filt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] pad = '0;

  logic        rvalid, err, rvalid8, err8;
  logic [31:0] rdata, rdata8;
  logic [31:0] gout, gen, intr;
  logic [7:0]  gout8, gen8, intr8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_filt #(.Width(32), .FiltCycles(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_we_i(we),
    .reg_addr_i(addr), .reg_wdata_i(wdata), .reg_rvalid_o(rvalid),
    .reg_rdata_o(rdata), .reg_error_o(err), .cio_gpio_i(pad),
    .cio_gpio_o(gout), .cio_gpio_en_o(gen), .intr_gpio_o(intr));

  gpio_filt #(.Width(8), .FiltCycles(16)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_we_i(we),
    .reg_addr_i(addr), .reg_wdata_i(wdata), .reg_rvalid_o(rvalid8),
    .reg_rdata_o(rdata8), .reg_error_o(err8), .cio_gpio_i(pad[7:0]),
    .cio_gpio_o(gout8), .cio_gpio_en_o(gen8), .intr_gpio_o(intr8));

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one access at the current negedge; return the response seen after the edge
  task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output logic v);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    rd = rdata; e = err; v = rvalid;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic e, v;
    bus(1'b1, a, d, rd, e, v);
  endtask

  function automatic void add(input logic w, input logic [5:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ee);
    vec_t t;
    t.we = w; t.addr = a; t.wdata = d; t.exp_rdata = er; t.exp_err = ee;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [31:0] rd, m_dout, m_oe, d, exp_rd;
    logic        e, v, exp_e;
    logic [5:0]  a;
    int          op;

    repeat (3) @(negedge clk);
    check("reset_gout", gout, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) add(1'b0, 6'(i * 4), 32'h0, 32'h0, 1'b0);
    add(1'b0, 6'h34, 32'h0, 32'h0, 1'b1);
    add(1'b0, 6'h05, 32'h0, 32'h0, 1'b1);
    add(1'b1, 6'h04, 32'h0000_00F0, 32'h0, 1'b0);
    add(1'b1, 6'h08, 32'h0000_000F, 32'h0, 1'b0);
    add(1'b1, 6'h0C, 32'h0000_0030, 32'h0, 1'b0);
    add(1'b1, 6'h3C, 32'hFFFF_FFFF, 32'h0, 1'b1);
    add(1'b1, 6'h06, 32'hFFFF_FFFF, 32'h0, 1'b1);
    add(1'b0, 6'h04, 32'h0, 32'h0000_00CF, 1'b0);
    add(1'b0, 6'h08, 32'h0, 32'h0, 1'b0);
    add(1'b0, 6'h0C, 32'h0, 32'h0, 1'b0);
    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, e, v);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_err", i), {31'h0, e}, {31'h0, tbl[i].exp_err});
      check($sformatf("tbl%0d_rvalid", i), {31'h0, v}, 32'h1);
    end
    check("gout_set_clr", gout, 32'h0000_00CF);

    // Unfiltered rising edge on pin 0
    wr(6'h20, 32'h1);
    wr(6'h1C, 32'h1);
    pad[0] = 1'b1;
    req = 1'b1; we = 1'b0; addr = 6'h00;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("unf_din_k%0d", k), {31'h0, rdata[0]}, {31'h0, (k - 1) >= 3});
      check($sformatf("unf_intr_k%0d", k), {31'h0, intr[0]}, {31'h0, k >= 4});
    end
    req = 1'b0;
    wr(6'h18, 32'h1);
    check("w1c_intr0", {31'h0, intr[0]}, 32'h0);
    bus(1'b0, 6'h18, 32'h0, rd, e, v);
    check("w1c_state", rd, 32'h0);
    pad[0] = 1'b0;

    // Filtered pin 3: short pulse rejected, long level accepted at edge 19
    wr(6'h14, 32'h8);
    wr(6'h20, 32'h8);
    wr(6'h1C, 32'h8);
    repeat (5) @(negedge clk);
    pad[3] = 1'b1;
    repeat (10) @(negedge clk);
    pad[3] = 1'b0;
    repeat (30) @(negedge clk);
    bus(1'b0, 6'h00, 32'h0, rd, e, v);
    check("pulse_din", rd, 32'h0);
    bus(1'b0, 6'h18, 32'h0, rd, e, v);
    check("pulse_state", rd, 32'h0);
    check("pulse_intr", intr, 32'h0);
    pad[3] = 1'b1;
    req = 1'b1; we = 1'b0; addr = 6'h00;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      check($sformatf("filt_din_k%0d", k), {31'h0, rdata[3]}, {31'h0, (k - 1) >= 19});
      check($sformatf("filt_intr_k%0d", k), {31'h0, intr[3]}, {31'h0, k >= 20});
    end
    req = 1'b0;

    // Level-high on pin 2 beats a same-cycle W1C; INTR_TEST sets pin 7
    pad[2] = 1'b1;
    wr(6'h28, 32'h4);
    wr(6'h1C, 32'h84);
    repeat (5) @(negedge clk);
    wr(6'h18, 32'h4);
    bus(1'b0, 6'h18, 32'h0, rd, e, v);
    check("lvl_w1c_state2", rd & 32'h4, 32'h4);
    wr(6'h30, 32'h80);
    bus(1'b0, 6'h18, 32'h0, rd, e, v);
    check("test_state", rd & 32'h84, 32'h84);
    check("test_intr", intr & 32'h84, 32'h84);
    wr(6'h18, 32'hFFFF_FFFF);
    bus(1'b0, 6'h18, 32'h0, rd, e, v);
    check("w1c_all_state", rd, 32'h4);
    bus(1'b0, 6'h30, 32'h0, rd, e, v);
    check("test_reads0", rd, 32'h0);

    // Randomized output-register traffic against a plain model
    m_dout = 32'h0000_00CF;
    m_oe   = 32'h0;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 6);
      d  = $urandom;
      exp_rd = 32'h0;
      exp_e  = 1'b0;
      case (op)
        0: begin a = 6'h04; m_dout = d; end
        1: begin a = 6'h08; m_dout = m_dout | d; end
        2: begin a = 6'h0C; m_dout = m_dout & ~d; end
        3: begin a = 6'h10; m_oe = d; end
        4: begin a = 6'h04; exp_rd = m_dout; end
        5: begin a = 6'h10; exp_rd = m_oe; end
        default: begin
          a = ($urandom_range(0, 1) == 0) ? 6'(52 + 4 * $urandom_range(0, 2))
                                          : 6'((4 * $urandom_range(0, 12)) | $urandom_range(1, 3));
          exp_e = 1'b1;
        end
      endcase
      bus((op <= 3) || (op == 6 && d[0]), a, d, rd, e, v);
      check($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      check($sformatf("rnd%0d_err", n), {31'h0, e}, {31'h0, exp_e});
      check($sformatf("rnd%0d_gout", n), gout, m_dout);
      check($sformatf("rnd%0d_gen", n), gen, m_oe);
    end

    // Width=8 instance ignores bits above its width
    wr(6'h10, 32'hFFFF_FFFF);
    check("w8_gen", {24'h0, gen8}, 32'h0000_00FF);
    check("w32_gen", gen, 32'hFFFF_FFFF);
    bus(1'b0, 6'h10, 32'h0, rd, e, v);
    check("w8_oe_read", rdata8, 32'h0000_00FF);
    check("w32_oe_read", rd, 32'hFFFF_FFFF);

    // Reset mid-access aborts the response and clears outputs
    req = 1'b1; we = 1'b0; addr = 6'h04;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_gout", gout, 32'h0);
    check("rst_gen", gen, 32'h0);
    check("rst_intr", intr, 32'h0);
    req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
